intvec_write_port: RTL and testbench

INTVEC_WRITE_PORT -- requirements
Module: intvec_write_port

---
 rtl/a4092_pkg.sv | 25 ++
 rtl/sync2.sv | 33 +++
 rtl/intvec_write_port.sv | 179 +++++++++++++++++
 tb/tb_intvec_write_port.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/a4092_pkg.sv
// rtl/a4092_pkg.sv - shared types and constants for the interrupt-vector write port
//
// Holds the write-port FSM state encoding, the default register address match
// value, the spurious-interrupt vector loaded at reset and the default
// WAIT_DS abort limit.

package a4092_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_DS = 2'd1,
    ST_LATCH   = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  // ADDR[23:17] match value; 7'h44 places the register at 0x880000.
  localparam logic [6:0] INTREG_ADDR_DEF = 7'h44;

  // Vector presented before the driver has programmed one.
  localparam logic [7:0] SPURIOUS_VEC = 8'h0F;

  // CLK cycles allowed in WAIT_DS before the cycle is abandoned (2..31).
  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with selectable reset value
//
// Ports:
//   CLK      in  system clock
//   RESET_n  in  asynchronous active-low reset; both flops load RST_VAL
//   i_d      in  asynchronous input
//   o_q      out synchronized copy of i_d, two CLK edges of latency

module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/intvec_write_port.sv
// rtl/intvec_write_port.sv - Zorro III interrupt-vector register write port
//
// Captures the byte-lane-0 write data of a Zorro III cycle addressed to
// INTREG_ADDR and holds it as the board's interrupt vector.
// Optional feature macro: INTVEC_READBACK_EN (adds read access and rd_dout).
//
// Ports:
//   CLK, RESET_n       clock; asynchronous active-low reset
//   FCS_n, DS0_n       asynchronous bus strobes (synchronized internally)
//   READ, LOCK         bus direction (1 = read) and Zorro LOCK
//   configured         board has been autoconfigured
//   ADDR[23:17]        address bits compared against INTREG_ADDR
//   D_IN[7:0]          byte-lane-0 write data
//   int_vector[7:0]    stored vector (SPURIOUS_VEC after reset)
//   int_assigned       stored vector is nonzero
//   wr_slave_n         SLAVE_n request, low while the port owns the cycle
//   wr_dtack_n         DTACK_n request, low in ACK
//   wr_timeout         one-cycle pulse when WAIT_DS is abandoned
//   rd_dout[7:0]       (INTVEC_READBACK_EN only) int_vector while DTACK is requested

module intvec_write_port
  import a4092_pkg::*;
#(
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [6:0] INTREG_ADDR = INTREG_ADDR_DEF
) (
  input  logic         CLK,
  input  logic         RESET_n,
  input  logic         FCS_n,
  input  logic         DS0_n,
  input  logic         READ,
  input  logic         LOCK,
  input  logic         configured,
  input  logic [23:17] ADDR,
  input  logic [7:0]   D_IN,
  output logic [7:0]   int_vector,
  output logic         int_assigned,
  output logic         wr_slave_n,
  output logic         wr_dtack_n,
  output logic         wr_timeout
`ifdef INTVEC_READBACK_EN
  ,
  output logic [7:0]   rd_dout
`endif
);

  // Count value seen during the last permitted WAIT_DS cycle.
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYC - 1);

  logic       w_fcs_s;
  logic       w_ds0_s;
  logic       w_fcs_fall;
  logic       w_hit;
  logic       w_latch;
  logic       w_wr_en;
  logic       w_timeout;
  state_t     w_next;

  state_t     r_state;
  logic       r_fcs_prev;
  logic [4:0] r_cnt;
  logic [7:0] r_vec;
  logic       r_asg;
  logic       r_slave_n;
  logic       r_dtack_n;
  logic       r_timeout;

  sync2 #(.RST_VAL(1'b1)) u_sync_fcs (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .i_d     (FCS_n),
    .o_q     (w_fcs_s)
  );

  sync2 #(.RST_VAL(1'b1)) u_sync_ds0 (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .i_d     (DS0_n),
    .o_q     (w_ds0_s)
  );

  assign w_fcs_fall = r_fcs_prev & ~w_fcs_s;

`ifdef INTVEC_READBACK_EN
  logic r_is_read;

  assign w_hit   = configured & ~LOCK & (ADDR == INTREG_ADDR);
  // Read cycles walk the same FSM but must not disturb the vector.
  assign w_wr_en = w_latch & ~r_is_read;
  assign rd_dout = r_dtack_n ? 8'h00 : r_vec;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_is_read <= 1'b0;
    end else if (r_state == ST_IDLE && w_next == ST_WAIT_DS) begin
      r_is_read <= READ;
    end
  end
`else
  assign w_hit   = configured & ~LOCK & (ADDR == INTREG_ADDR) & ~READ;
  assign w_wr_en = w_latch;
`endif

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fcs_fall && w_hit) w_next = ST_WAIT_DS;
      end
      ST_WAIT_DS: begin
        // Losing FCS outranks a late data strobe.
        if (w_fcs_s) begin
          w_next = ST_IDLE;
        end else if (!w_ds0_s) begin
          w_next = ST_LATCH;
        end else if (r_cnt == TMO_LAST) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_LATCH: begin
        // The vector is only taken if FCS is still held through LATCH.
        if (w_fcs_s) begin
          w_next = ST_IDLE;
        end else begin
          w_latch = 1'b1;
          w_next  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (w_fcs_s) begin
          w_next = ST_IDLE;
        end else if (w_ds0_s) begin
          w_next = ST_WAIT_DS;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus-facing outputs are decoded from the next state so they change on
  // the same edge as the state register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= ST_IDLE;
      r_fcs_prev <= 1'b1;
      r_cnt      <= '0;
      r_vec      <= SPURIOUS_VEC;
      r_asg      <= 1'b0;
      r_slave_n  <= 1'b1;
      r_dtack_n  <= 1'b1;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_fcs_prev <= w_fcs_s;
      r_slave_n  <= (w_next == ST_IDLE);
      r_dtack_n  <= (w_next != ST_ACK);
      r_timeout  <= w_timeout;
      if (r_state != ST_WAIT_DS) begin
        r_cnt <= '0;
      end else if (r_cnt != 5'h1F) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_wr_en) begin
        r_vec <= D_IN;
        r_asg <= (D_IN != 8'h00);
      end
    end
  end

  assign int_vector   = r_vec;
  assign int_assigned = r_asg;
  assign wr_slave_n   = r_slave_n;
  assign wr_dtack_n   = r_dtack_n;
  assign wr_timeout   = r_timeout;

endmodule

// File: tb/tb_intvec_write_port.sv
// tb/tb_intvec_write_port.sv - self-checking bench for intvec_write_port

module tb_intvec_write_port;

  localparam int TMO = 16;

  logic         CLK = 1'b0;
  logic         RESET_n = 1'b0;
  logic         FCS_n = 1'b1;
  logic         DS0_n = 1'b1;
  logic         READ = 1'b0;
  logic         LOCK = 1'b0;
  logic         configured = 1'b1;
  logic [23:17] ADDR = 7'h00;
  logic [7:0]   D_IN = 8'h00;
  logic [7:0]   int_vector;
  logic         int_assigned;
  logic         wr_slave_n;
  logic         wr_dtack_n;
  logic         wr_timeout;
`ifdef INTVEC_READBACK_EN
  logic [7:0]   rd_dout;
`endif

  int checks = 0;
  int errors = 0;

  int dtack_falls = 0;
  int slave_low = 0;
  int to_pulses = 0;
  logic prev_dtack = 1'b1;

  logic [7:0] exp_vec;
  logic       exp_asg;

  intvec_write_port #(.TIMEOUT_CYC(TMO), .INTREG_ADDR(7'h44)) dut (
    .CLK          (CLK),
    .RESET_n      (RESET_n),
    .FCS_n        (FCS_n),
    .DS0_n        (DS0_n),
    .READ         (READ),
    .LOCK         (LOCK),
    .configured   (configured),
    .ADDR         (ADDR),
    .D_IN         (D_IN),
    .int_vector   (int_vector),
    .int_assigned (int_assigned),
    .wr_slave_n   (wr_slave_n),
    .wr_dtack_n   (wr_dtack_n),
    .wr_timeout   (wr_timeout)
`ifdef INTVEC_READBACK_EN
    ,
    .rd_dout      (rd_dout)
`endif
  );

  always #5 CLK = ~CLK;

  // Event monitor sampled just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (prev_dtack && !wr_dtack_n) dtack_falls++;
    if (!wr_slave_n) slave_low++;
    if (wr_timeout) to_pulses++;
    prev_dtack = wr_dtack_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: the port claims a cycle only for a configured, unlocked
  // access to the register address; reads only when readback exists.
  function automatic bit is_hit(input logic [6:0] a, input logic rd, input logic lk, input logic cf);
`ifdef INTVEC_READBACK_EN
    return cf && !lk && (a == 7'h44);
`else
    return cf && !lk && (a == 7'h44) && !rd;
`endif
  endfunction

  // One full bus cycle with 1 or 2 data beats, DS0_n low 6 cycles per beat.
  task automatic xfer(input logic [6:0] a, input logic rd, input logic lk, input logic cf,
                      input int nbeats, input logic [7:0] d0, input logic [7:0] d1,
                      output int falls, output int lat0, output int slow, output logic [7:0] rdv);
    int base_f;
    int base_s;
    lat0 = -1;
    rdv  = 8'h00;
    @(negedge CLK);
    ADDR = a; READ = rd; LOCK = lk; configured = cf; FCS_n = 1'b0;
    base_f = dtack_falls;
    base_s = slave_low;
    repeat (4) @(negedge CLK);
    for (int b = 0; b < nbeats; b++) begin
      D_IN  = (b == 0) ? d0 : d1;
      DS0_n = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge CLK);
        if (b == 0 && lat0 < 0 && !wr_dtack_n) begin
          lat0 = k;
`ifdef INTVEC_READBACK_EN
          rdv = rd_dout;
`endif
        end
      end
      DS0_n = 1'b1;
      repeat (4) @(negedge CLK);
    end
    FCS_n = 1'b1;
    repeat (4) @(negedge CLK);
    falls = dtack_falls - base_f;
    slow  = slave_low - base_s;
    READ = 1'b0; LOCK = 1'b0; configured = 1'b1;
  endtask

  // Drives a transfer and compares it with the model's expectations.
  task automatic run_and_check(input string tag, input logic [6:0] a, input logic rd,
                               input logic lk, input logic cf, input int nbeats,
                               input logic [7:0] d0, input logic [7:0] d1);
    int falls;
    int lat0;
    int slow;
    logic [7:0] rdv;
    bit hit;
    logic [7:0] vec_before;
    hit = is_hit(a, rd, lk, cf);
    vec_before = exp_vec;
    xfer(a, rd, lk, cf, nbeats, d0, d1, falls, lat0, slow, rdv);
    if (hit && !rd) begin
      exp_vec = (nbeats == 2) ? d1 : d0;
      exp_asg = (exp_vec != 8'h00);
    end
    chk({tag, "_dtack_pulses"}, falls, hit ? nbeats : 0);
    chk({tag, "_dtack_latency"}, lat0, hit ? 4 : -1);
    chk({tag, "_slave_claimed"}, (slow > 0), hit);
    chk({tag, "_vector"}, int_vector, exp_vec);
    chk({tag, "_assigned"}, int_assigned, exp_asg);
    chk({tag, "_slave_released"}, wr_slave_n, 1'b1);
`ifdef INTVEC_READBACK_EN
    if (hit && rd) chk({tag, "_rd_dout"}, rdv, vec_before);
`endif
  endtask

  initial begin
    int t_slave;
    int t_to;
    int to_base;
    int guard;
    logic [6:0] a;
    logic rd;
    logic lk;
    logic cf;
    int kind;

    exp_vec = 8'h0F;
    exp_asg = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_vector", int_vector, 8'h0F);
    chk("rst_assigned", int_assigned, 1'b0);
    chk("rst_slave", wr_slave_n, 1'b1);
    chk("rst_dtack", wr_dtack_n, 1'b1);
    chk("rst_timeout", wr_timeout, 1'b0);

    // Basic write of 0x18, then a two-beat burst where the last beat wins
    run_and_check("wr18", 7'h44, 1'b0, 1'b0, 1'b1, 1, 8'h18, 8'h00);
    run_and_check("burst", 7'h44, 1'b0, 1'b0, 1'b1, 2, 8'h20, 8'h24);

    // Cycles the port must ignore
    run_and_check("lock", 7'h44, 1'b0, 1'b1, 1'b1, 1, 8'h55, 8'h00);
    run_and_check("unconf", 7'h44, 1'b0, 1'b0, 1'b0, 1, 8'h66, 8'h00);
    run_and_check("addr45", 7'h45, 1'b0, 1'b0, 1'b1, 1, 8'h77, 8'h00);
    run_and_check("read", 7'h44, 1'b1, 1'b0, 1'b1, 1, 8'h88, 8'h00);
    run_and_check("unassign", 7'h44, 1'b0, 1'b0, 1'b1, 1, 8'h00, 8'h00);
    run_and_check("wr5a", 7'h44, 1'b0, 1'b0, 1'b1, 1, 8'h5A, 8'h00);

    // Timeout: FCS held, DS0 never asserted
    @(negedge CLK);
    ADDR = 7'h44; READ = 1'b0; LOCK = 1'b0; configured = 1'b1; FCS_n = 1'b0;
    to_base = to_pulses;
    t_slave = -1;
    t_to = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (t_slave < 0 && !wr_slave_n) t_slave = i;
      if (t_to < 0 && wr_timeout) begin
        t_to = i;
        chk("tmo_slave_released", wr_slave_n, 1'b1);
      end
    end
    chk("tmo_seen", (t_to >= 0), 1'b1);
    chk("tmo_interval", t_to - t_slave, TMO);
    chk("tmo_single_pulse", to_pulses - to_base, 1);
    chk("tmo_vector", int_vector, exp_vec);
    FCS_n = 1'b1;
    repeat (4) @(negedge CLK);

    // Reset asserted while DTACK is being requested
    ADDR = 7'h44; FCS_n = 1'b0;
    repeat (4) @(negedge CLK);
    D_IN = 8'h31; DS0_n = 1'b0;
    guard = 0;
    while (wr_dtack_n && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    chk("ack_reached", wr_dtack_n, 1'b0);
    #2;
    RESET_n = 1'b0;
    FCS_n = 1'b1;
    DS0_n = 1'b1;
    #1;
    exp_vec = 8'h0F;
    exp_asg = 1'b0;
    chk("arst_vector", int_vector, 8'h0F);
    chk("arst_assigned", int_assigned, 1'b0);
    chk("arst_slave", wr_slave_n, 1'b1);
    chk("arst_dtack", wr_dtack_n, 1'b1);
    chk("arst_timeout", wr_timeout, 1'b0);
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_idle", wr_slave_n, 1'b1);
    run_and_check("post_rst_wr", 7'h44, 1'b0, 1'b0, 1'b1, 1, 8'h42, 8'h00);
    run_and_check("post_rst_rd", 7'h44, 1'b1, 1'b0, 1'b1, 1, 8'h99, 8'h00);

    // Randomized cycles against the transaction-level model
    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 5);
      a  = 7'h44;
      rd = 1'b0;
      lk = 1'b0;
      cf = 1'b1;
      case (kind)
        2: lk = 1'b1;
        3: cf = 1'b0;
        4: rd = 1'b1;
        5: a = 7'($urandom_range(0, 127));
        default: ;
      endcase
      run_and_check($sformatf("rnd%0d", n), a, rd, lk, cf, $urandom_range(1, 2),
                    ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                    ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
